// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA raster timing receiver: locks to hsync/vsync, regenerates position and flags timing faults
module vga_sync_rx #(
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_SYNC_ST  = 656,
    parameter int H_SYNC_LEN = 96,
    parameter int V_SYNC_ST  = 490,
    parameter int V_SYNC_LEN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixel_en,
    input  logic        hsync_n,
    input  logic        vsync_n,
    output logic [9:0]  col,
    output logic [9:0]  row,
    output logic        active,
    output logic [18:0] addr,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_count
);

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_ST   = 10'(H_SYNC_ST);
    localparam logic [9:0] HS_END  = 10'(H_SYNC_ST + H_SYNC_LEN);
    localparam logic [9:0] VS_ST   = 10'(V_SYNC_ST);
    localparam logic [9:0] VS_END  = 10'(V_SYNC_ST + V_SYNC_LEN);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        HLOCK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state, state_d;
    logic        hs_prev, vs_prev;
    logic        hs_fall, vs_fall;
    logic [9:0]  col_n, row_n;
    logic        hs_exp, vs_exp;
    logic        err;
    logic [9:0]  col_d, row_d;
    logic [18:0] addr_d;
    logic        active_d, fs_d, locked_d;
    logic [7:0]  cnt_d;

    assign hs_fall = hs_prev & ~hsync_n;
    assign vs_fall = vs_prev & ~vsync_n;
    assign col_n   = (col == H_LAST) ? 10'd0 : col + 10'd1;
    assign row_n   = (col != H_LAST) ? row : ((row == V_LAST) ? 10'd0 : row + 10'd1);
    assign hs_exp  = !((col_n >= HS_ST) && (col_n < HS_END));
    assign vs_exp  = !((row_n >= VS_ST) && (row_n < VS_END));

    always_comb begin
        state_d  = state;
        col_d    = col;
        row_d    = row;
        addr_d   = addr;
        active_d = 1'b0;
        fs_d     = 1'b0;
        err      = 1'b0;
        case (state)
            HUNT: begin
                if (hs_fall) begin
                    col_d   = HS_ST;
                    state_d = HLOCK;
                end
            end
            HLOCK: begin
                col_d = col_n;
                // vsync is judged first, so a coincident hsync edge never masks a good vertical lock
                if (vs_fall) begin
                    if (col_n == 10'd0) begin
                        row_d   = VS_ST;
                        col_d   = 10'd0;
                        state_d = LOCKED;
                    end else begin
                        err = 1'b1;
                    end
                end else if (hs_fall && (col_n != HS_ST)) begin
                    err = 1'b1;
                end
            end
            LOCKED: begin
                if ((hsync_n != hs_exp) || (vsync_n != vs_exp)) begin
                    err = 1'b1;
                end else begin
                    col_d    = col_n;
                    row_d    = row_n;
                    active_d = (col_n < H_ACT) && (row_n < V_ACT);
                    if ((col_n == 10'd0) && (row_n == 10'd0)) begin
                        addr_d = 19'd0;
                        fs_d   = 1'b1;
                    end else if (active_d) begin
                        addr_d = addr + 19'd1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
        if (err) begin
            state_d  = HUNT;
            col_d    = 10'd0;
            row_d    = 10'd0;
            addr_d   = 19'd0;
            active_d = 1'b0;
        end
        locked_d = (state_d == LOCKED);
        cnt_d    = (err && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            col         <= 10'd0;
            row         <= 10'd0;
            addr        <= 19'd0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= 8'd0;
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
        end else if (pixel_en) begin
            state       <= state_d;
            col         <= col_d;
            row         <= row_d;
            addr        <= addr_d;
            active      <= active_d;
            frame_start <= fs_d;
            locked      <= locked_d;
            sync_err    <= err;
            err_count   <= cnt_d;
            hs_prev     <= hsync_n;
            vs_prev     <= vsync_n;
        end else begin
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - self-checking bench for vga_sync_rx on a reduced raster
module tb_vga_sync_rx;

    localparam int HT = 40;
    localparam int VT = 20;
    localparam int HA = 32;
    localparam int VA = 12;
    localparam int HS = 33;
    localparam int HL = 4;
    localparam int VS = 14;
    localparam int VL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pixel_en;
    logic        hsync_n;
    logic        vsync_n;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        active;
    logic [18:0] addr;
    logic        frame_start;
    logic        locked;
    logic        sync_err;
    logic [7:0]  err_count;

    vga_sync_rx #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_SYNC_ST(HS), .H_SYNC_LEN(HL), .V_SYNC_ST(VS), .V_SYNC_LEN(VL)
    ) dut (
        .clk(clk), .rst(rst), .pixel_en(pixel_en), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .col(col), .row(row), .active(active), .addr(addr), .frame_start(frame_start),
        .locked(locked), .sync_err(sync_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // reference receiver: 0 = hunting, 1 = line-locked, 2 = frame-locked
    int mstate, mcol, mrow, maddr, mcnt;
    int mact, mfs, mlk, mse, mhp, mvp;
    int sx, sy;
    int fs_seen, se_seen;

    function automatic int hs_level(int c);
        return (c >= HS && c < HS + HL) ? 0 : 1;
    endfunction

    function automatic int vs_level(int r);
        return (r >= VS && r < VS + VL) ? 0 : 1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mstate = 0; mcol = 0; mrow = 0; maddr = 0; mcnt = 0;
        mact = 0; mfs = 0; mlk = 0; mse = 0; mhp = 1; mvp = 1;
    endtask

    task automatic model_step(input int en, input int hs, input int vs);
        int fh, fv, cn, rn, e;
        mfs = 0;
        mse = 0;
        if (en == 0) return;
        fh = (mhp == 1 && hs == 0) ? 1 : 0;
        fv = (mvp == 1 && vs == 0) ? 1 : 0;
        mhp = hs;
        mvp = vs;
        cn = (mcol + 1) % HT;
        rn = (mcol == HT - 1) ? (mrow + 1) % VT : mrow;
        e = 0;
        if (mstate == 0) begin
            if (fh == 1) begin mcol = HS; mstate = 1; end
        end else if (mstate == 1) begin
            if (fv == 1) begin
                if (cn == 0) begin mrow = VS; mcol = 0; mstate = 2; end
                else e = 1;
            end else if (fh == 1 && cn != HS) e = 1;
            else mcol = cn;
        end else begin
            if (hs != hs_level(cn) || vs != vs_level(rn)) e = 1;
            else begin
                mcol = cn;
                mrow = rn;
                if (cn == 0 && rn == 0) mfs = 1;
                if (cn < HA && rn < VA) maddr = rn * HA + cn;
            end
        end
        if (e == 1) begin
            mstate = 0; mcol = 0; mrow = 0; maddr = 0;
            if (mcnt < 255) mcnt++;
        end
        mse = e;
        mlk = (mstate == 2) ? 1 : 0;
        mact = (mstate == 2 && mcol < HA && mrow < VA) ? 1 : 0;
    endtask

    task automatic check_all();
        chk("col", int'(col), mcol);
        chk("row", int'(row), mrow);
        chk("addr", int'(addr), maddr);
        chk("active", int'(active), mact);
        chk("frame_start", int'(frame_start), mfs);
        chk("locked", int'(locked), mlk);
        chk("sync_err", int'(sync_err), mse);
        chk("err_count", int'(err_count), mcnt);
    endtask

    task automatic cyc(input int en, input int hs, input int vs);
        pixel_en = en[0];
        hsync_n  = hs[0];
        vsync_n  = vs[0];
        @(posedge clk);
        #1;
        model_step(en, hs, vs);
        check_all();
        if (frame_start) fs_seen++;
        if (sync_err) se_seen++;
    endtask

    // one source pixel followed by an idle clock (pixel_en every second clk)
    task automatic src_pix(input int hs_lo, input int vs_lo);
        int hs, vs;
        hs = (hs_lo != 0) ? 0 : hs_level(sx);
        vs = (vs_lo != 0) ? 0 : vs_level(sy);
        cyc(1, hs, vs);
        cyc(0, hs, vs);
        sx++;
        if (sx == HT) begin
            sx = 0;
            sy = (sy + 1) % VT;
        end
    endtask

    task automatic do_reset();
        pixel_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    task automatic wait_lock(input string tag);
        for (int i = 0; i < 3 * HT * VT && !locked; i++) src_pix(0, 0);
        chk(tag, int'(locked), 1);
    endtask

    initial begin
        int px, py;
        rst = 1'b1; pixel_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1;
        model_reset();
        fs_seen = 0; se_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // clean stream starting mid-line
        sx = 10; sy = 3;
        wait_lock("lock_acquired");
        chk("lock_row", int'(row), VS);
        chk("lock_col", int'(col), 0);
        fs_seen = 0; se_seen = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            px = sx; py = sy;
            src_pix(0, 0);
            if (px == HA - 1 && py == VA - 1) chk("last_addr", int'(addr), HA * VA - 1);
            if (px == 0 && py == 0) chk("frame_addr0", int'(addr), 0);
        end
        chk("frame_starts", fs_seen, 2);
        chk("clean_errs", se_seen, 0);

        // premature hsync one column early
        for (int i = 0; i < HT && sx != HS - 1; i++) src_pix(0, 0);
        se_seen = 0;
        src_pix(1, 0);
        chk("early_hs_err", se_seen, 1);
        chk("early_hs_count", int'(err_count), 1);
        chk("early_hs_unlock", int'(locked), 0);
        wait_lock("relock");

        // pixel_en held low mid-line in the active area
        for (int i = 0; i < 2 * HT * VT && !(sx == 7 && sy == 2); i++) src_pix(0, 0);
        fs_seen = 0; se_seen = 0;
        for (int i = 0; i < 100; i++) cyc(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        chk("freeze_col", int'(col), 6);
        chk("freeze_row", int'(row), 2);
        chk("freeze_addr", int'(addr), 2 * HA + 6);
        chk("freeze_pulses", fs_seen + se_seen, 0);
        for (int i = 0; i < 5; i++) src_pix(0, 0);

        // reset while locked, then relock
        do_reset();
        chk("rst_unlock", int'(locked), 0);
        wait_lock("relock_after_rst");

        // vsync falling at column 5 while line-locked
        do_reset();
        sx = 20; sy = 0;
        for (int i = 0; i < 2 * HT && !(sx == 5 && sy == 1); i++) src_pix(0, 0);
        se_seen = 0;
        src_pix(0, 1);
        chk("vs_col5_err", se_seen, 1);
        chk("vs_col5_row", int'(row), 0);
        chk("vs_col5_unlock", int'(locked), 0);

        // random inputs, then a clean raster with sparse random glitches
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 7) != 0) ? 1 : 0,
                ($urandom_range(0, 31) != 0) ? 1 : 0);
        for (int i = 0; i < 1500; i++)
            src_pix(($urandom_range(0, 399) == 0) ? 1 : 0, ($urandom_range(0, 799) == 0) ? 1 : 0);

        // error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cyc(1, 1, 1);
            cyc(1, 0, 1);
            cyc(1, 1, 1);
            cyc(1, 0, 1);
        end
        chk("sat_count", int'(err_count), 255);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 1);
            cyc(1, 0, 1);
            cyc(1, 1, 1);
            cyc(1, 0, 1);
        end
        chk("sat_hold", int'(err_count), 255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
